// File: rtl/mem_model_pkg.sv
// Shared types and address-geometry helpers for the line responder.
package mem_model_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int offset_bits(input int line_bytes);
        return (line_bytes > 1) ? $clog2(line_bytes) : 0;
    endfunction

    // Floor of 1 keeps the index slice legal for a single-line memory.
    function automatic int index_bits(input int mem_lines);
        return (mem_lines > 1) ? $clog2(mem_lines) : 1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// Request/response bus between a line initiator and the line responder.
interface mem_line_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16
);
    // Handshake: the initiator raises mem_req_valid with rw/addr/wdata stable and may
    // hold it until mem_resp_valid pulses for one cycle; the responder only samples
    // the request while idle, so a held request is accepted once per completion.
    logic                      mem_req_valid;
    logic                      mem_req_rw;
    logic [ADDR_WIDTH-1:0]     mem_req_addr;
    logic [LINE_BYTES*8-1:0]   mem_req_wdata;
    logic                      mem_resp_valid;
    logic [LINE_BYTES*8-1:0]   mem_resp_rdata;
    logic                      busy;
    logic [15:0]               rd_count;
    logic [15:0]               wr_count;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
        input  mem_resp_valid, mem_resp_rdata, busy, rd_count, wr_count
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
        output mem_resp_valid, mem_resp_rdata, busy, rd_count, wr_count
    );
endinterface

// File: rtl/mem_line_array.sv
// Single-port line storage: synchronous write, registered (write-first) read, no reset.
module mem_line_array #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
                rdata_q  <= wdata;
            end else begin
                rdata_q  <= mem[idx];
            end
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency line memory model: accepts one read or writeback at a time and
// answers with a one-cycle response pulse after LATENCY+1 edges.
module mem_line_responder
    import mem_model_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int MEM_LINES  = 64,
    parameter int LATENCY    = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    mem_line_responder_if.slave bus,
    output state_t state_dbg
);
    localparam int DATA_W = LINE_BYTES * 8;
    localparam int OFF_W  = offset_bits(LINE_BYTES);
    localparam int IDX_W  = index_bits(MEM_LINES);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               rw_q, rw_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [15:0]        rd_count_q, rd_count_d;
    logic [15:0]        wr_count_q, wr_count_d;
    logic               arr_en;
    logic               arr_we;
    logic [DATA_W-1:0]  arr_rdata;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^bus.mem_req_addr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        arr_en     = 1'b0;
        arr_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_req_valid) begin
                    state_d = WAIT;
                    rw_d    = bus.mem_req_rw;
                    idx_d   = bus.mem_req_addr[OFF_W +: IDX_W];
                    wdata_d = bus.mem_req_wdata;
                    cnt_d   = 8'(LATENCY);
                end
            end
            WAIT: begin
                // Array access is issued only here, so a reset during WAIT drops the write.
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    arr_en  = 1'b1;
                    arr_we  = rw_q;
                    if (rw_q) wr_count_d = sat_inc16(wr_count_q);
                    else      rd_count_d = sat_inc16(rd_count_q);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                hold_d  = arr_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            rw_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            hold_q     <= '0;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    mem_line_array #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_LINES),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // The array register carries the fresh line during RESP; hold_q keeps it afterwards.
    assign bus.mem_resp_valid = (state_q == RESP);
    assign bus.mem_resp_rdata = (state_q == RESP) ? arr_rdata : hold_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.rd_count       = rd_count_q;
    assign bus.wr_count       = wr_count_q;
    assign state_dbg          = state_q;
endmodule
